hp54542c_frame_lock_ctrl: RTL and testbench

Frame-lock sequencer for the HP54542C LCD-to-VGA path. Watches the LCD sync strobe in the pixel-clock domain, finds the vertical gap, confirms a stable frame shape over several frames, then issues the frame-start and line-start strobes and the lock flag that gate the VGA timing generator and RGB blanking. Lock is dropped on repeated malformed frames or on loss of sync.

---
 rtl/hp54542c_frame_lock_ctrl.sv | 156 +++++++++++++++
 tb/tb_hp54542c_frame_lock_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hp54542c_frame_lock_ctrl.sv
// Frame-lock sequencer: qualifies LCD sync frames and gates the VGA timing path
// with frame/line strobes and a lock flag once the frame shape is stable.
module hp54542c_frame_lock_ctrl #(
    parameter int unsigned P_LINES         = 480,
    parameter int unsigned P_LINE_CLKS     = 800,
    parameter int unsigned P_LINE_TOL      = 4,
    parameter int unsigned P_VGAP_MIN      = 1000,
    parameter int unsigned P_LOCK_FRAMES   = 3,
    parameter int unsigned P_UNLOCK_MISSES = 2,
    parameter int unsigned P_TIMEOUT       = 500000
) (
    input  logic       iw_clk,
    input  logic       iw_reset,
    input  logic       iw_sync,
    output logic       ow_locked,
    output logic       ow_frame_start,
    output logic       ow_line_start,
    output logic [1:0] ow_state,
    output logic [9:0] ow_line_count,
    output logic [7:0] ow_err_count
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [18:0] GAP_MAX  = '1;
    localparam logic [18:0] GAP_VMIN = 19'(P_VGAP_MIN);
    localparam logic [18:0] GAP_LO   = 19'(P_LINE_CLKS - P_LINE_TOL);
    localparam logic [18:0] GAP_HI   = 19'(P_LINE_CLKS + P_LINE_TOL);
    localparam logic [18:0] GAP_TO   = 19'(P_TIMEOUT);
    localparam logic [9:0]  LINES_N  = 10'(P_LINES);
    localparam logic [7:0]  LOCK_N   = 8'(P_LOCK_FRAMES);
    localparam logic [7:0]  MISS_N   = 8'(P_UNLOCK_MISSES);

    state_t      state_q, state_d;
    logic        sync_q;
    logic [18:0] gap_q, gap_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic        frame_bad_q, frame_bad_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  miss_q, miss_d;
    logic [7:0]  err_q, err_d;
    logic        frame_start_q, frame_start_d;
    logic        line_start_q, line_start_d;

    logic sync_edge, boundary, line_ok, frame_good, timeout;

    always_comb begin
        sync_edge  = iw_sync & ~sync_q;
        boundary   = sync_edge && (gap_q > GAP_VMIN);
        line_ok    = (gap_q >= GAP_LO) && (gap_q <= GAP_HI);
        frame_good = (line_cnt_q == LINES_N) && !frame_bad_q;
        // an edge on the threshold cycle takes precedence over the timeout
        timeout    = !sync_edge && (gap_q == GAP_TO);
    end

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        line_cnt_d  = line_cnt_q;
        frame_bad_d = frame_bad_q;
        good_d      = good_q;
        miss_d      = miss_q;
        err_d       = err_q;

        if (sync_edge) begin
            gap_d = 19'd1;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 19'd1;
        end

        if (boundary) begin
            line_cnt_d  = 10'd1;
            frame_bad_d = 1'b0;
        end else if (sync_edge) begin
            if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 10'd1;
            if (!line_ok) frame_bad_d = 1'b1;
        end

        if (timeout) begin
            state_d = ST_SEARCH;
            if (state_q == ST_LOCKED && err_q != '1) err_d = err_q + 8'd1;
        end else if (boundary) begin
            unique case (state_q)
                ST_SEARCH: begin
                    state_d = ST_VERIFY;
                    good_d  = '0;
                end
                ST_VERIFY: begin
                    if (frame_good) begin
                        good_d = good_q + 8'd1;
                        if (good_q + 8'd1 == LOCK_N) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (frame_good) begin
                        miss_d = '0;
                    end else begin
                        miss_d = miss_q + 8'd1;
                        if (miss_q + 8'd1 == MISS_N) begin
                            state_d = ST_SEARCH;
                            if (err_q != '1) err_d = err_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        // strobes follow the post-edge state so lock and unlock edges line up with ow_locked
        frame_start_d = boundary && (state_d == ST_LOCKED);
        line_start_d  = sync_edge && (state_d == ST_LOCKED);
    end

    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            state_q       <= ST_SEARCH;
            sync_q        <= 1'b0;
            gap_q         <= '0;
            line_cnt_q    <= '0;
            frame_bad_q   <= 1'b0;
            good_q        <= '0;
            miss_q        <= '0;
            err_q         <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= iw_sync;
            gap_q         <= gap_d;
            line_cnt_q    <= line_cnt_d;
            frame_bad_q   <= frame_bad_d;
            good_q        <= good_d;
            miss_q        <= miss_d;
            err_q         <= err_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign ow_locked      = (state_q == ST_LOCKED);
    assign ow_frame_start = frame_start_q;
    assign ow_line_start  = line_start_q;
    assign ow_state       = state_q;
    assign ow_line_count  = line_cnt_q;
    assign ow_err_count   = err_q;

endmodule

// File: tb/tb_hp54542c_frame_lock_ctrl.sv
// Scoreboard bench for hp54542c_frame_lock_ctrl using a scaled-down frame shape
// so acquisition, jitter, timeout and reset scenarios stay short.
module tb_hp54542c_frame_lock_ctrl;

    localparam int LINES = 8;
    localparam int LCLK  = 20;
    localparam int TOL   = 4;
    localparam int VGAP  = 40;
    localparam int LOCKF = 3;
    localparam int MISSN = 2;
    localparam int TO    = 200;
    localparam int VTAIL = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic       ow_locked, ow_frame_start, ow_line_start;
    logic [1:0] ow_state;
    logic [9:0] ow_line_count;
    logic [7:0] ow_err_count;

    hp54542c_frame_lock_ctrl #(
        .P_LINES        (LINES),
        .P_LINE_CLKS    (LCLK),
        .P_LINE_TOL     (TOL),
        .P_VGAP_MIN     (VGAP),
        .P_LOCK_FRAMES  (LOCKF),
        .P_UNLOCK_MISSES(MISSN),
        .P_TIMEOUT      (TO)
    ) u_dut (
        .iw_clk        (clk),
        .iw_reset      (rst),
        .iw_sync       (sync),
        .ow_locked     (ow_locked),
        .ow_frame_start(ow_frame_start),
        .ow_line_start (ow_line_start),
        .ow_state      (ow_state),
        .ow_line_count (ow_line_count),
        .ow_err_count  (ow_err_count)
    );

    always #5 clk = ~clk;

    typedef logic [22:0] obs_t;
    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // reference model state, indexed by clock cycle number
    int   m_t = 0, m_anchor = 0, m_state = 0, m_lc = 0, m_good = 0, m_miss = 0, m_err = 0;
    logic m_prev = 1'b0, m_bad = 1'b0;

    task automatic model_step(input logic s, input logic r, output obs_t o);
        int   gap;
        logic e, fs, ls, fg;
        fs = 1'b0;
        ls = 1'b0;
        if (r) begin
            m_state = 0; m_lc = 0; m_bad = 1'b0; m_good = 0; m_miss = 0; m_err = 0;
            m_prev = 1'b0;
            m_anchor = m_t + 1;
        end else begin
            gap = m_t - m_anchor;
            if (gap > 524287) gap = 524287;
            e = s && !m_prev;
            if (!e && gap == TO) begin
                if (m_state == 2 && m_err < 255) m_err++;
                m_state = 0;
            end else if (e) begin
                if (gap > VGAP) begin
                    fg = (m_lc == LINES) && !m_bad;
                    case (m_state)
                        0: begin m_state = 1; m_good = 0; end
                        1: begin
                            if (fg) begin
                                m_good++;
                                if (m_good == LOCKF) begin m_state = 2; m_miss = 0; end
                            end else m_state = 0;
                        end
                        default: begin
                            if (fg) m_miss = 0;
                            else begin
                                m_miss++;
                                if (m_miss == MISSN) begin
                                    m_state = 0;
                                    if (m_err < 255) m_err++;
                                end
                            end
                        end
                    endcase
                    m_lc  = 1;
                    m_bad = 1'b0;
                    fs    = (m_state == 2);
                end else begin
                    if (m_lc < 1023) m_lc++;
                    if (gap < LCLK - TOL || gap > LCLK + TOL) m_bad = 1'b1;
                end
                ls = (m_state == 2);
                m_anchor = m_t;
            end
            m_prev = s;
        end
        m_t++;
        o = {m_state == 2, fs, ls, 2'(m_state), 10'(m_lc), 8'(m_err)};
    endtask

    int   since_edge = 0;
    logic prev_drv   = 1'b0;

    task automatic step(input logic s, input logic r);
        obs_t o, want;
        sync = s;
        rst  = r;
        model_step(s, r, o);
        exp_q.push_back(o);
        if (s && !prev_drv && !r) since_edge = 0;
        else since_edge++;
        prev_drv = r ? 1'b0 : s;
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        chk("cycle", 32'({ow_locked, ow_frame_start, ow_line_start, ow_state,
                          ow_line_count, ow_err_count}), 32'(want));
    endtask

    int b_state, b_locked, b_fs, b_err, ls_cnt;

    // n edges: boundary first, line edges after; odd replaces the 2nd line gap
    task automatic frame(input int n, input int odd, input int tail);
        ls_cnt = 0;
        for (int i = 0; i < n; i++) begin
            int g;
            g = (i == n - 1) ? tail : ((i == 1 && odd != 0) ? odd : LCLK);
            step(1'b1, 1'b0);
            if (i == 0) begin
                b_state  = int'(ow_state);
                b_locked = int'(ow_locked);
                b_fs     = int'(ow_frame_start);
                b_err    = int'(ow_err_count);
            end
            ls_cnt += int'(ow_line_start);
            repeat (g - 1) begin
                step(1'b0, 1'b0);
                ls_cnt += int'(ow_line_start);
            end
        end
    endtask

    initial begin
        int n;
        rst  = 1'b1;
        sync = 1'b0;
        repeat (3) step(1'b0, 1'b1);
        chk("rst_state", 32'(ow_state), 0);
        chk("rst_locked", 32'(ow_locked), 0);
        chk("rst_lines", 32'(ow_line_count), 0);
        chk("rst_err", 32'(ow_err_count), 0);
        repeat (60) step(1'b0, 1'b0);

        // clean acquisition
        frame(LINES, 0, VTAIL);
        chk("verify_b1", b_state, 1);
        frame(LINES, 0, VTAIL);
        frame(LINES, 0, VTAIL);
        chk("still_verify", b_state, 1);
        frame(LINES, 0, VTAIL);
        chk("lock_state", b_state, 2);
        chk("lock_flag", b_locked, 1);
        chk("lock_fs", b_fs, 1);
        chk("ls_lock_frame", ls_cnt, LINES);
        frame(LINES, 0, VTAIL);
        chk("ls_per_frame", ls_cnt, LINES);

        // jitter tolerance
        frame(LINES, LCLK - TOL, VTAIL);
        frame(LINES, LCLK + TOL, VTAIL);
        frame(LINES, 0, VTAIL);
        chk("jit_keep", b_locked, 1);
        frame(LINES, LCLK + TOL + 1, VTAIL);
        frame(LINES, 0, VTAIL);
        chk("one_bad_keep", b_locked, 1);
        frame(LINES, 0, VTAIL);
        chk("recover_keep", b_locked, 1);
        frame(LINES, LCLK + TOL + 1, VTAIL);
        frame(LINES, LCLK + TOL + 1, VTAIL);
        chk("miss1_keep", b_locked, 1);
        frame(LINES, 0, VTAIL);
        chk("unlock", b_locked, 0);
        chk("unlock_state", b_state, 0);
        chk("unlock_err", b_err, 1);

        // short frame while verifying
        frame(LINES, 0, VTAIL);
        chk("search_to_verify", b_state, 1);
        frame(LINES - 1, 0, VTAIL);
        chk("verify_hold", b_state, 1);
        frame(LINES, 0, VTAIL);
        chk("short_drop", b_state, 0);
        frame(LINES, 0, VTAIL);
        chk("reverify", b_state, 1);
        frame(LINES, 0, VTAIL);
        frame(LINES, 0, VTAIL);
        frame(LINES, 0, VTAIL);
        chk("relock", b_state, 2);

        // sync loss
        n = 0;
        while (ow_locked && n < 1000) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("to_drop", 32'(ow_locked), 0);
        chk("to_latency", since_edge, TO);
        chk("to_err", 32'(ow_err_count), 2);

        // edge exactly on the timeout threshold
        frame(LINES, 0, VTAIL);
        frame(LINES, 0, VTAIL);
        frame(LINES, 0, VTAIL);
        frame(LINES, 0, TO);
        chk("relock2", b_state, 2);
        frame(LINES, 0, VTAIL);
        chk("edge_on_to_lock", b_locked, 1);
        chk("edge_on_to_err", b_err, 2);
        chk("edge_on_to_fs", b_fs, 1);

        // reset mid-line while locked, coincident with an edge
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        chk("pre_rst_locked", 32'(ow_locked), 1);
        step(1'b1, 1'b1);
        chk("rst_mid_locked", 32'(ow_locked), 0);
        chk("rst_mid_fs", 32'(ow_frame_start), 0);
        chk("rst_mid_ls", 32'(ow_line_start), 0);
        chk("rst_mid_state", 32'(ow_state), 0);
        chk("rst_mid_lines", 32'(ow_line_count), 0);
        chk("rst_mid_err", 32'(ow_err_count), 0);
        step(1'b0, 1'b0);
        chk("post_rst_ls", 32'(ow_line_start), 0);
        chk("post_rst_state", 32'(ow_state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
